// File: rtl/memory_dp_clr.sv
// Dual-port word memory with a one-word-per-cycle clean sweep that writes FILL_VALUE.
// Optional macro MEMORY_DP_CLR_RDW_BYPASS_EN: same-address read/write returns the new write data.
module memory_dp_clr #(
   parameter int                  DATA_SIZE   = 14,
   parameter int                  ADDR_SIZE   = 19,
   parameter int                  MEMORY_SIZE = 10,
   parameter logic [DATA_SIZE-1:0] FILL_VALUE = '0
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_wr_en,
   input  logic [ADDR_SIZE-1:0] i_wr_addr,
   input  logic [DATA_SIZE-1:0] i_wr_data,
   input  logic                 i_rd_en,
   input  logic [ADDR_SIZE-1:0] i_rd_addr,
   input  logic                 i_clean,
   output logic [DATA_SIZE-1:0] o_rd_data,
   output logic                 o_rd_valid,
   output logic                 o_busy,
   output logic                 o_clean_done,
   output logic                 o_addr_err
);

   localparam int PTR_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
   // One extra bit so MEMORY_SIZE == 2^ADDR_SIZE is still representable.
   localparam logic [ADDR_SIZE:0] MEM_LIMIT = (ADDR_SIZE+1)'(MEMORY_SIZE);
   localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(MEMORY_SIZE - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAN = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 clean_done_q, clean_done_d;
   logic                 addr_err_q, addr_err_d;

   logic [DATA_SIZE-1:0] mem_q [MEMORY_SIZE];
   logic                 mem_we;
   logic [PTR_W-1:0]     mem_waddr;
   logic [DATA_SIZE-1:0] mem_wdata;

   logic                 wr_ok;
   logic                 rd_ok;
   logic [PTR_W-1:0]     wr_idx;
   logic [PTR_W-1:0]     rd_idx;

   assign wr_ok  = {1'b0, i_wr_addr} < MEM_LIMIT;
   assign rd_ok  = {1'b0, i_rd_addr} < MEM_LIMIT;
   assign wr_idx = i_wr_addr[PTR_W-1:0];
   assign rd_idx = i_rd_addr[PTR_W-1:0];

   // State register
   always_ff @(posedge i_clock) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
   end

   // Next-state logic; reset overrides everything, including a pending i_clean.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (i_reset) begin
         state_d = ST_IDLE;
         ptr_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_clean) begin
                  state_d = ST_CLEAN;
                  ptr_d   = '0;
               end
            end
            ST_CLEAN: begin
               if (ptr_q == LAST_PTR) begin
                  state_d = ST_IDLE;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + PTR_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         endcase
      end
   end

   // Output / datapath logic
   always_comb begin
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      clean_done_d = 1'b0;
      addr_err_d   = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = wr_idx;
      mem_wdata    = i_wr_data;
      if (i_reset) begin
         rd_data_d = '0;
      end else if (state_q == ST_IDLE) begin
         if (i_rd_en) begin
            rd_valid_d = 1'b1;
            if (!rd_ok) begin
               rd_data_d = FILL_VALUE;
            end else begin
`ifdef MEMORY_DP_CLR_RDW_BYPASS_EN
               if (i_wr_en && wr_ok && (i_wr_addr == i_rd_addr))
                  rd_data_d = i_wr_data;
               else
                  rd_data_d = mem_q[rd_idx];
`else
               rd_data_d = mem_q[rd_idx];
`endif
            end
         end
         mem_we     = i_wr_en && wr_ok;
         addr_err_d = (i_wr_en && !wr_ok) || (i_rd_en && !rd_ok);
      end else begin
         mem_we       = 1'b1;
         mem_waddr    = ptr_q;
         mem_wdata    = FILL_VALUE;
         clean_done_d = (ptr_q == LAST_PTR);
      end
   end

   always_ff @(posedge i_clock) begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      clean_done_q <= clean_done_d;
      addr_err_q   <= addr_err_d;
   end

   // Storage is deliberately not reset; only the sweep clears it.
   always_ff @(posedge i_clock) begin
      if (mem_we)
         mem_q[mem_waddr] <= mem_wdata;
   end

   assign o_rd_data    = rd_data_q;
   assign o_rd_valid   = rd_valid_q;
   assign o_busy       = (state_q == ST_CLEAN);
   assign o_clean_done = clean_done_q;
   assign o_addr_err   = addr_err_q;

endmodule

// File: tb/tb_memory_dp_clr.sv
// Scoreboard bench for memory_dp_clr: a reference model queues expected responses,
// a negedge monitor pops and compares them.
module tb_memory_dp_clr;

   localparam int              DW   = 14;
   localparam int              AW   = 19;
   localparam int              MS   = 10;
   localparam logic [DW-1:0]   FILL = '0;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          clean;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic          clean_done;
   logic          addr_err;

   always #5 clk = ~clk;

   memory_dp_clr #(
      .DATA_SIZE(DW), .ADDR_SIZE(AW), .MEMORY_SIZE(MS), .FILL_VALUE(FILL)
   ) dut (
      .i_clock(clk), .i_reset(rst),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_clean(clean),
      .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy),
      .o_clean_done(clean_done), .o_addr_err(addr_err)
   );

   typedef struct {
      logic [DW-1:0] data;
      bit            valid;
      bit            busy;
      bit            done;
      bit            err;
   } status_t;

   status_t       st_q[$];
   logic [DW-1:0] rd_q[$];
   int            errors = 0;
   int            checks = 0;
   bit            mon_en = 1'b0;

`ifdef MEMORY_DP_CLR_RDW_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // Reference model: plain array plus "sweep in progress" and its next word.
   logic [DW-1:0] m_mem [MS];
   bit            m_sweep = 1'b0;
   int            m_idx   = 0;
   logic [DW-1:0] m_last  = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit we, input int wa, input int wd,
                       input bit re, input int ra, input bit cl);
      status_t s;
      logic [DW-1:0] v;
      rst = r; wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
      rd_en = re; rd_addr = AW'(ra); clean = cl;
      s.valid = 1'b0; s.done = 1'b0; s.err = 1'b0;
      if (r) begin
         m_sweep = 1'b0;
         m_last  = '0;
      end else if (m_sweep) begin
         m_mem[m_idx] = FILL;
         m_idx++;
         if (m_idx == MS) begin
            m_sweep = 1'b0;
            s.done  = 1'b1;
         end
      end else begin
         if (re) begin
            if (ra >= MS)                           v = FILL;
            else if (BYPASS && we && wa == ra)      v = DW'(wd);
            else                                    v = m_mem[ra];
            rd_q.push_back(v);
            m_last  = v;
            s.valid = 1'b1;
         end
         if (we && wa < MS) m_mem[wa] = DW'(wd);
         s.err = (we && wa >= MS) || (re && ra >= MS);
         if (cl) begin
            m_sweep = 1'b1;
            m_idx   = 0;
         end
      end
      s.busy = m_sweep;
      s.data = m_last;
      st_q.push_back(s);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int a, input int d);
      step(0, 1, a, d, 0, 0, 0);
   endtask

   task automatic rd(input int a);
      step(0, 0, 0, 0, 1, a, 0);
   endtask

   task automatic read_all();
      for (int i = 0; i < MS; i++) rd(i);
   endtask

   task automatic fill_all(input int d);
      for (int i = 0; i < MS; i++) wr(i, d);
   endtask

   // Monitor: one expected status per clock, read data popped whenever the DUT flags valid.
   always @(negedge clk) begin
      status_t s;
      if (mon_en) begin
         if (st_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL status_underflow: got empty queue expected entry at %0t", $time);
         end else begin
            s = st_q.pop_front();
            chk("busy", busy, s.busy);
            chk("clean_done", clean_done, s.done);
            chk("addr_err", addr_err, s.err);
            chk("rd_valid", rd_valid, s.valid);
            chk("rd_data_hold", rd_data, s.data);
            if (rd_valid) begin
               if (rd_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rd_unexpected: got %0h expected no read at %0t", rd_data, $time);
               end else begin
                  chk("rd_data", rd_data, rd_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
      idle();
      for (int i = 0; i < MS; i++) wr(i, int'($urandom_range(0, 16'h3FFF)));
      read_all();

      // Basic write then read on the next cycle
      wr(3, 14'h1ABC);
      rd(3);
      idle();

      // Same-address read and write in one cycle, then read back
      step(0, 1, 2, 14'h0055, 1, 2, 0);
      rd(2);

      // Out-of-range write and read in the same cycle: one error pulse, nothing written
      step(0, 1, 10, 14'h1234, 1, 12, 0);
      idle();
      step(0, 1, 19'h7FFFF, 14'h0AAA, 0, 0, 0);
      rd(19'h40000);
      read_all();

      // Full sweep with ignored traffic while busy, then a restart on the done cycle
      fill_all(14'h3FFF);
      step(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < MS; k++) begin
         if (k == MS - 1) step(0, 1, 9, 14'h3FFF, 0, 0, 0);
         else             step(0, 1, k, 14'h2222, 1, k, 1);
      end
      read_all();
      fill_all(14'h3FFF);
      step(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < MS; k++) idle();
      step(0, 1, 4, 14'h0101, 1, 5, 1);
      for (int k = 0; k < MS; k++) idle();
      read_all();

      // Reset on the fifth busy cycle aborts the sweep
      fill_all(14'h3FFF);
      step(0, 0, 0, 0, 0, 0, 1);
      for (int k = 1; k <= 4; k++) idle();
      step(1, 1, 7, 14'h0001, 1, 7, 1);
      idle();
      idle();
      read_all();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int wa, ra;
         wa = ($urandom_range(0, 15) == 0) ? 19'h7FFFF : int'($urandom_range(0, 12));
         ra = ($urandom_range(0, 15) == 0) ? 19'h50000 : int'($urandom_range(0, 12));
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, wa,
              int'($urandom_range(0, 16'h3FFF)), $urandom_range(0, 1) == 1, ra,
              $urandom_range(0, 24) == 0);
      end
      for (int k = 0; k < MS + 2; k++) idle();
      read_all();

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("status_queue_drained", st_q.size(), 0);
      chk("read_queue_drained", rd_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_dp_clr.md
MEMORY_DP_CLR -- requirements
Module: memory_dp_clr

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 14, word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 19, address width in bits.
REQ-003 SHALL have parameter MEMORY_SIZE, default 10, number of words, 1 to 2^ADDR_SIZE.
REQ-004 SHALL have parameter FILL_VALUE, default 0 (DATA_SIZE bits), word written by the clean sweep.
REQ-005 SHALL have port i_clock  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_wr_en  input  1  write request.
REQ-008 SHALL have port i_wr_addr  input  ADDR_SIZE  write address.
REQ-009 SHALL have port i_wr_data  input  DATA_SIZE  write data.
REQ-010 SHALL have port i_rd_en  input  1  read request.
REQ-011 SHALL have port i_rd_addr  input  ADDR_SIZE  read address.
REQ-012 SHALL have port i_clean  input  1  start clean sweep.
REQ-013 SHALL have port o_rd_data  output  DATA_SIZE  registered read data.
REQ-014 SHALL have port o_rd_valid  output  1  o_rd_data updated this cycle.
REQ-015 SHALL have port o_busy  output  1  clean sweep in progress.
REQ-016 SHALL have port o_clean_done  output  1  one-cycle pulse, sweep finished.
REQ-017 SHALL have port o_addr_err  output  1  one-cycle pulse, out-of-range access.

Function
REQ-018 SHALL implement FSM states IDLE and CLEAN; IDLE->CLEAN on i_clean sampled high in IDLE; CLEAN->IDLE after the write to address MEMORY_SIZE-1.
REQ-019 SHALL, in IDLE, perform read and write independently in the same cycle (separate ports).
REQ-020 SHALL have read latency 1: i_rd_en at edge N -> o_rd_data valid and o_rd_valid=1 after edge N+1, o_rd_valid=0 otherwise.
REQ-021 SHALL hold o_rd_data unchanged when no read completes.
REQ-022 SHALL commit a write at the edge where i_wr_en is sampled high.
REQ-023 SHALL, for an address >= MEMORY_SIZE, drop the write, return FILL_VALUE with o_rd_valid=1 for a read, and pulse o_addr_err one cycle after the access; both ports bad in one cycle -> single pulse.
REQ-024 SHALL, in CLEAN, write FILL_VALUE to one word per cycle, ascending from 0: exactly MEMORY_SIZE writes, no write beyond MEMORY_SIZE-1.
REQ-025 SHALL assert o_busy from the cycle after i_clean is sampled through the cycle of the last clean write, i.e. exactly MEMORY_SIZE cycles.
REQ-026 SHALL pulse o_clean_done for one cycle, the first cycle with o_busy=0 after the sweep.
REQ-027 SHALL, while o_busy=1, ignore i_wr_en, i_rd_en and i_clean: no memory change, o_rd_valid=0, o_addr_err=0.
REQ-028 SHALL, when i_clean coincides with i_wr_en/i_rd_en in IDLE, perform the access first and start the sweep next cycle.
REQ-029 SHALL accept a new i_clean in the cycle o_clean_done is high.

Reset
REQ-030 SHALL on i_reset set o_rd_data=0, o_rd_valid=0, o_busy=0, o_clean_done=0, o_addr_err=0, state IDLE, sweep pointer 0.
REQ-031 SHALL NOT reset memory contents; reset during CLEAN aborts the sweep, leaves already-cleaned words cleaned, and produces no o_clean_done.
REQ-032 SHALL give i_reset priority over every other input in the same cycle.

Configuration
REQ-033 SHALL support macro MEMORY_DP_CLR_RDW_BYPASS_EN: when defined, a read and write to the same valid address in one cycle returns i_wr_data (new data).
REQ-034 SHALL, without MEMORY_DP_CLR_RDW_BYPASS_EN, return the pre-write contents (old data) in that case.

Verification (DATA_SIZE=14, MEMORY_SIZE=10, FILL_VALUE=0)
REQ-035 SHALL cover: write 0x1ABC @3, read @3 next cycle -> o_rd_data=0x1ABC, o_rd_valid=1 exactly one cycle later.
REQ-036 SHALL cover: write 0x0055 @2 and read @2 same cycle -> 0x0055 with macro, prior value without.
REQ-037 SHALL cover: fill all 10 words with 0x3FFF, pulse i_clean -> o_busy high 10 cycles, o_clean_done one pulse, reads 0..9 return 0; one cycle before the pulse, a write of 0x3FFF @9 during busy is ignored.
REQ-038 SHALL cover: write @10 and read @12 -> memory unchanged, o_rd_data=0, single o_addr_err pulse.
REQ-039 SHALL cover: i_reset on 5th busy cycle -> o_busy=0 next cycle, no o_clean_done, words 0..3 read 0, words 4..9 keep 0x3FFF.
